coarse_seq: RTL and testbench

//  Sequencer for the coarse-system ladder switch network and Schmitt trigger (_DC1.._DC12 -> _TLC1H).

---
 rtl/coarse_if.sv | 16 +
 rtl/coarse_seq.sv | 144 ++++++++++++++
 tb/tb_coarse_seq.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/coarse_if.sv
// Handshake/bus bundle between the read counter side and the coarse ladder sequencer.
interface coarse_if;
  logic        enable;
  logic [5:0]  coarse_ang;
  logic        tlc1h;
  logic [11:0] dc;
  logic        cnt_up;
  logic        cnt_dn;
  logic        busy;
  logic        coarse_err;

  modport master (output enable, coarse_ang, tlc1h,
                  input  dc, cnt_up, cnt_dn, busy, coarse_err);
  modport slave  (input  enable, coarse_ang, tlc1h,
                  output dc, cnt_up, cnt_dn, busy, coarse_err);
endinterface

// File: rtl/coarse_seq.sv
// Coarse ladder sequencer: drives _DC1.._DC12, samples _TLC1H with DC12 on/off, pulses the read counter.
// Optional COARSE_SYNC_EN adds a 2-flop synchronizer on tlc1h.
module coarse_seq #(
  parameter int SETTLE    = 16,
  parameter int HOLDOFF   = 4,
  parameter int ERR_LIMIT = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  coarse_if.slave  bus
);
  localparam int TMAX = (SETTLE > HOLDOFF) ? SETTLE : HOLDOFF;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int EW   = $clog2(ERR_LIMIT + 1);

  typedef enum logic [2:0] {IDLE, SETTLE_H, SETTLE_L, DECIDE, HOLD} state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [EW-1:0]   errcnt;
  logic [5:0]      code;
  logic            h;
  logic [11:0]     dc_q;
  logic            up_q, dn_q, busy_q, err_q;
  logic            tlc_s;

`ifdef COARSE_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= '0;
    else        sync <= {sync[0], bus.tlc1h};
  assign tlc_s = sync[1];
`else
  assign tlc_s = bus.tlc1h;
`endif

  // {DC12 bias, DC11..DC9 = ang[0..2], DC8..DC1 = octant pair}
  function automatic logic [11:0] dc_code(input logic [5:0] ang, input logic bias);
    logic [7:0] pair;
    case (ang[5:3])
      3'd0:    pair = 8'h88;
      3'd1:    pair = 8'h44;
      3'd2:    pair = 8'h14;
      3'd3:    pair = 8'h28;
      3'd4:    pair = 8'h22;
      3'd5:    pair = 8'h11;
      3'd6:    pair = 8'h41;
      default: pair = 8'h82;
    endcase
    return {bias, ang[0], ang[1], ang[2], pair};
  endfunction

  logic [EW-1:0] errcnt_inc;
  assign errcnt_inc = (errcnt < EW'(ERR_LIMIT)) ? errcnt + 1'b1 : errcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      timer  <= '0;
      errcnt <= '0;
      code   <= '0;
      h      <= 1'b0;
      dc_q   <= '0;
      up_q   <= 1'b0;
      dn_q   <= 1'b0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      up_q <= 1'b0;
      dn_q <= 1'b0;
      if (state != IDLE && !bus.enable) begin
        // abort: measurement discarded, error history kept
        state  <= IDLE;
        dc_q   <= '0;
        busy_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            dc_q <= '0;
            if (bus.enable) begin
              code   <= bus.coarse_ang;
              dc_q   <= dc_code(bus.coarse_ang, 1'b1);
              timer  <= TW'(SETTLE - 1);
              busy_q <= 1'b1;
              state  <= SETTLE_H;
            end else begin
              err_q  <= 1'b0;
            end
          end
          SETTLE_H: begin
            if (timer == '0) begin
              h     <= tlc_s;
              dc_q  <= dc_code(code, 1'b0);
              timer <= TW'(SETTLE - 1);
              state <= SETTLE_L;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          SETTLE_L: begin
            if (timer == '0) begin
              dc_q  <= '0;
              state <= DECIDE;
              // tlc_s here is the low-bias sample l
              if (h == tlc_s) begin
                up_q   <= h;
                dn_q   <= ~h;
                errcnt <= errcnt_inc;
                if (errcnt_inc == EW'(ERR_LIMIT)) err_q <= 1'b1;
              end else begin
                errcnt <= '0;
              end
            end else begin
              timer <= timer - 1'b1;
            end
          end
          DECIDE: begin
            timer <= TW'(HOLDOFF - 1);
            state <= HOLD;
          end
          HOLD: begin
            if (timer == '0) begin
              busy_q <= 1'b0;
              state  <= IDLE;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          default: begin
            dc_q   <= '0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.dc         = dc_q;
  assign bus.cnt_up     = up_q;
  assign bus.cnt_dn     = dn_q;
  assign bus.busy       = busy_q;
  assign bus.coarse_err = err_q;
endmodule

// File: tb/tb_coarse_seq.sv
// Scoreboard bench for coarse_seq: per-cycle expected outputs queued at drive time, popped on negedge.
module tb_coarse_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  coarse_if bus();
  coarse_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [11:0] dc;
    logic up, dn, busy, err;
  } exp_t;

  exp_t sbq[$];
  int   nvec = 0;
  int   nerr = 0;
  int   errcnt_m = 0;
  logic err_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // independent model of the switch pattern from the DC-number table
  function automatic logic [11:0] exp_dc(input logic [5:0] ang, input logic bias);
    int pa[8] = '{4, 3, 3, 4, 2, 1, 1, 2};
    int pb[8] = '{8, 7, 5, 6, 6, 5, 7, 8};
    logic [11:0] d;
    int o;
    o = int'(ang[5:3]);
    d = '0;
    d[pa[o]-1] = 1'b1;
    d[pb[o]-1] = 1'b1;
    d[8]  = ang[2];
    d[9]  = ang[1];
    d[10] = ang[0];
    d[11] = bias;
    return d;
  endfunction

  task automatic push(input logic [11:0] dc, input logic up, input logic dn,
                      input logic busy, input logic err);
    exp_t e;
    e.dc = dc; e.up = up; e.dn = dn; e.busy = busy; e.err = err;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("dc",   32'(bus.dc),         32'(e.dc));
      chk("up",   32'(bus.cnt_up),     32'(e.up));
      chk("dn",   32'(bus.cnt_dn),     32'(e.dn));
      chk("busy", 32'(bus.busy),       32'(e.busy));
      chk("err",  32'(bus.coarse_err), 32'(e.err));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.enable = 1'b0;
      err_m = 1'b0;
      push('0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
  endtask

  // entered in cycle 0 (IDLE); leaves in cycle 38 (IDLE) unless aborted/reset
  task automatic run_meas(input logic [5:0] ang, input logic th, input logic tl,
                          input int abort_at = 0, input int chg_at = 0, input int rst_at = 0);
    logic [11:0] dh, dl;
    logic up, dn;
    dh = exp_dc(ang, 1'b1);
    dl = exp_dc(ang, 1'b0);
    up = th & tl;
    dn = ~th & ~tl;
    for (int k = 0; k < 38; k++) begin
      int n;
      if (rst_at != 0 && k == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_dc",   32'(bus.dc),         32'h0);
        chk("rst_up",   32'(bus.cnt_up),     32'h0);
        chk("rst_dn",   32'(bus.cnt_dn),     32'h0);
        chk("rst_busy", 32'(bus.busy),       32'h0);
        chk("rst_err",  32'(bus.coarse_err), 32'h0);
        bus.enable = 1'b0;
        errcnt_m = 0;
        err_m = 1'b0;
        step();
        rst_n = 1'b1;
        return;
      end
      if (k == 0) begin
        bus.enable = 1'b1;
        bus.coarse_ang = ang;
        bus.tlc1h = th;
      end
      if (k == 17) bus.tlc1h = tl;
      if (chg_at != 0 && k == chg_at) bus.coarse_ang = ~ang;
      if (abort_at != 0 && k == abort_at) begin
        bus.enable = 1'b0;
        push('0, 1'b0, 1'b0, 1'b0, err_m);
        step();
        return;
      end
      n = k + 1;
      if (n <= 16)      push(dh, 1'b0, 1'b0, 1'b1, err_m);
      else if (n <= 32) push(dl, 1'b0, 1'b0, 1'b1, err_m);
      else if (n == 33) begin
        if (up || dn) begin
          if (errcnt_m < 8) errcnt_m++;
          if (errcnt_m == 8) err_m = 1'b1;
        end else begin
          errcnt_m = 0;
        end
        push('0, up, dn, 1'b1, err_m);
      end
      else if (n <= 37) push('0, 1'b0, 1'b0, 1'b1, err_m);
      else              push('0, 1'b0, 1'b0, 1'b0, err_m);
      step();
    end
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.coarse_ang = '0;
    bus.tlc1h = 1'b0;
    rst_n = 1'b0;
    repeat (2) step();
    chk("por_dc",   32'(bus.dc),   32'h0);
    chk("por_busy", 32'(bus.busy), 32'h0);
    chk("por_err",  32'(bus.coarse_err), 32'h0);
    rst_n = 1'b1;
    idle(3);

    // correction up, then a split decision that clears the error count
    run_meas(6'b000101, 1'b1, 1'b1);
    run_meas(6'b101000, 1'b1, 1'b0);

    // eight back-to-back down corrections set the sticky error, a ninth keeps it
    for (int i = 0; i < 9; i++)
      run_meas(6'($urandom_range(0, 63)), 1'b0, 1'b0);
    run_meas(6'b111011, 1'b0, 1'b1);
    idle(3);

    // abort mid SETTLE_L, then code change mid measurement
    run_meas(6'b010110, 1'b1, 1'b1, 20);
    idle(2);
    run_meas(6'b000101, 1'b1, 1'b1, 0, 5);
    run_meas(6'b011001, 1'b0, 1'b0);

    // async reset in SETTLE_L
    run_meas(6'b110100, 1'b1, 1'b1, 0, 0, 24);
    idle(3);
    run_meas(6'b100111, 1'b0, 1'b0);
    idle(2);

    chk("sbq_empty", 32'(sbq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
